// File: rtl/sobol_rng.sv
// Single-dimension Sobol sequence generator (Gray-code order) built around the lsz encoder.
// Optional macro SOBOL_DV_LOAD_EN adds a writable direction-vector register file.

module lsz #(
   parameter int BITWIDTH    = 8,
   parameter int LOGBITWIDTH = 3
) (
   input  logic [BITWIDTH-1:0]    iGray,
   output logic [BITWIDTH-1:0]    oLszOneHot,
   output logic [LOGBITWIDTH-1:0] lszIdx
);

   // Lowest zero bit isolated: all-ones input yields an all-zero one-hot.
   assign oLszOneHot = ~iGray & (iGray + {{(BITWIDTH-1){1'b0}}, 1'b1});

   // One-hot to binary index encoder.
   always_comb begin
      lszIdx = {LOGBITWIDTH{1'b0}};
      for (int k = 0; k < BITWIDTH; k++) begin
         lszIdx = lszIdx | (oLszOneHot[k] ? LOGBITWIDTH'(k) : {LOGBITWIDTH{1'b0}});
      end
   end

endmodule

module sobol_rng #(
   parameter int BITWIDTH    = 8,
   parameter int LOGBITWIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iEn,
`ifdef SOBOL_DV_LOAD_EN
   input  logic                   iDvWe,
   input  logic [LOGBITWIDTH-1:0] iDvIdx,
   input  logic [BITWIDTH-1:0]    iDvData,
`endif
   output logic [BITWIDTH-1:0]    oSobol,
   output logic                   oValid,
   output logic                   oWrap
);

   function automatic logic [BITWIDTH-1:0] default_dv(input int k);
      return {{(BITWIDTH-1){1'b0}}, 1'b1} << (BITWIDTH - 1 - k);
   endfunction

   logic [BITWIDTH-1:0]    cnt_r;
   logic [BITWIDTH-1:0]    out_r;
   logic                   valid_r;
   logic                   wrap_r;
   logic [BITWIDTH-1:0]    dv_s [BITWIDTH];
   logic [BITWIDTH-1:0]    onehot_s;
   logic [LOGBITWIDTH-1:0] lsz_idx_s;
   logic [BITWIDTH-1:0]    sel_dv_s;
   logic                   last_s;

   lsz #(
      .BITWIDTH   (BITWIDTH),
      .LOGBITWIDTH(LOGBITWIDTH)
   ) u_lsz (
      .iGray     (cnt_r),
      .oLszOneHot(onehot_s),
      .lszIdx    (lsz_idx_s)
   );

`ifdef SOBOL_DV_LOAD_EN
   logic [BITWIDTH-1:0] dv_r [BITWIDTH];
   logic                dv_idx_ok_s;

   assign dv_idx_ok_s = ({1'b0, iDvIdx} < (LOGBITWIDTH+1)'(BITWIDTH));

   // Direction-vector register file; writes land after this cycle's XOR.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < BITWIDTH; k++) begin
            dv_r[k] <= default_dv(k);
         end
      end else if (iDvWe && dv_idx_ok_s) begin
         dv_r[iDvIdx] <= iDvData;
      end
   end

   // Expose the register file to the datapath.
   always_comb begin
      for (int k = 0; k < BITWIDTH; k++) begin
         dv_s[k] = dv_r[k];
      end
   end
`else
   // Fixed van der Corput vectors, pure wiring.
   always_comb begin
      for (int k = 0; k < BITWIDTH; k++) begin
         dv_s[k] = default_dv(k);
      end
   end
`endif

   assign sel_dv_s = dv_s[lsz_idx_s];
   assign last_s   = ~|onehot_s;

   // Index counter, output accumulator and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r   <= {BITWIDTH{1'b0}};
         out_r   <= {BITWIDTH{1'b0}};
         valid_r <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         valid_r <= iEn;
         if (iEn) begin
            if (last_s) begin
               cnt_r  <= {BITWIDTH{1'b0}};
               out_r  <= {BITWIDTH{1'b0}};
               wrap_r <= 1'b1;
            end else begin
               cnt_r  <= cnt_r + {{(BITWIDTH-1){1'b0}}, 1'b1};
               out_r  <= out_r ^ sel_dv_s;
               wrap_r <= 1'b0;
            end
         end else begin
            wrap_r <= 1'b0;
         end
      end
   end

   assign oSobol = out_r;
   assign oValid = valid_r;
   assign oWrap  = wrap_r;

endmodule
